fmdll_m_counter: RTL and testbench

Programmable modulo counter that generates the `M_counter` phase count and the active ratio `M` consumed by the FMDLL divide-by-M stage. It cycles 0..M on `clk_ext`, accepts ratio changes at any time, and applies them only at a count boundary so the downstream divider never sees a truncated or stretched period. It also issues a one-cycle wrap pulse and a reference-injection select for the delay line.

---
 rtl/fmdll_m_counter_if.sv | 27 ++
 rtl/fmdll_m_counter.sv | 118 +++++++++++
 tb/tb_fmdll_m_counter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fmdll_m_counter_if.sv
// fmdll_m_counter_if
//   Bundles the ratio-control and count signals of the FMDLL M counter.
//   master : the ratio controller. It drives en, m_load and m_req, and it
//            observes the count outputs.
//   slave  : the counter itself. It receives the controls and drives M,
//            M_counter, wrap, sel_ref, m_busy and m_err.
interface fmdll_m_counter_if;
  logic       en;         // count enable
  logic       m_load;     // one-cycle ratio change request
  logic [1:0] m_req;      // requested ratio (1..3 legal)
  logic [1:0] M;          // active ratio to the divide-by-M stage
  logic [1:0] M_counter;  // current phase count, 0..M
  logic       wrap;       // one-cycle pulse when the count returns to 0
  logic       sel_ref;    // reference-injection select for the delay line
  logic       m_busy;     // ratio update pending
  logic       m_err;      // sticky illegal-request flag

  modport master (
    output en, m_load, m_req,
    input  M, M_counter, wrap, sel_ref, m_busy, m_err
  );

  modport slave (
    input  en, m_load, m_req,
    output M, M_counter, wrap, sel_ref, m_busy, m_err
  );
endinterface

// File: rtl/fmdll_m_counter.sv
// fmdll_m_counter
//   Programmable modulo counter for the FMDLL divide-by-M stage. The counter
//   cycles 0..M on clk_ext. A ratio change can be requested at any time, but
//   it takes effect only at a count boundary. The boundaries are a wrap in
//   RUN, or any edge in IDLE or ALIGN. Because of this the divider never sees
//   a truncated or stretched period.
// Ports
//   clk_ext : external reference clock. All state changes on its rising edge.
//   rst_n   : asynchronous, active-low reset.
//   bus     : slave side of fmdll_m_counter_if
//             (en, m_load, m_req in; M, M_counter, wrap, sel_ref, m_busy, m_err out)
// Parameters
//   M_RST   : ratio loaded at reset (legal values 1..3)
module fmdll_m_counter #(
  parameter logic [1:0] M_RST = 2'd2
) (
  input  logic                clk_ext,
  input  logic                rst_n,
  fmdll_m_counter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t     state, state_nx;

  logic [1:0] m_cur,   m_nx;
  logic [1:0] cnt,     cnt_nx;
  logic [1:0] m_pend,  pend_nx;
  logic       wrap_r,  wrap_nx;
  logic       sel_r,   sel_nx;
  logic       busy_r,  busy_nx;
  logic       err_r,   err_nx;

  logic       at_top;
  logic       apply;
  logic       req_ok;
  logic       req_bad;

  // State and output registers. Every output is taken straight from a flop.
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      m_cur  <= M_RST;
      cnt    <= 2'd0;
      m_pend <= M_RST;
      wrap_r <= 1'b0;
      sel_r  <= 1'b0;
      busy_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state  <= state_nx;
      m_cur  <= m_nx;
      cnt    <= cnt_nx;
      m_pend <= pend_nx;
      wrap_r <= wrap_nx;
      sel_r  <= sel_nx;
      busy_r <= busy_nx;
      err_r  <= err_nx;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.en) state_nx = ALIGN;
      ALIGN:   state_nx = bus.en ? RUN : IDLE;
      RUN:     if (!bus.en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output and datapath decode
  always_comb begin
    // A wrap happens only when RUN continues through the top count. Dropping
    // en at the top count returns to IDLE without a wrap pulse.
    at_top  = (state == RUN) && bus.en && (cnt == m_cur);
    req_ok  = bus.m_load && (bus.m_req != 2'd0);
    req_bad = bus.m_load && (bus.m_req == 2'd0);

    // The count is 0 at every point where the ratio can change, so a smaller
    // ratio can never leave the count above M.
    apply   = busy_r && ((state == IDLE) || (state == ALIGN) || at_top);

    if ((state == RUN) && bus.en)
      cnt_nx = at_top ? 2'd0 : cnt + 2'd1;
    else
      cnt_nx = 2'd0;

    wrap_nx = at_top;
    sel_nx  = (state_nx == RUN) && (cnt_nx == 2'd0);

    // The pending value is applied before a same-edge request replaces it.
    // A new request therefore waits for the next boundary.
    m_nx    = apply ? m_pend : m_cur;
    pend_nx = req_ok ? bus.m_req : m_pend;

    if (req_ok)     busy_nx = 1'b1;
    else if (apply) busy_nx = 1'b0;
    else            busy_nx = busy_r;

    if (req_ok)       err_nx = 1'b0;
    else if (req_bad) err_nx = 1'b1;
    else              err_nx = err_r;
  end

  assign bus.M         = m_cur;
  assign bus.M_counter = cnt;
  assign bus.wrap      = wrap_r;
  assign bus.sel_ref   = sel_r;
  assign bus.m_busy    = busy_r;
  assign bus.m_err     = err_r;

endmodule

// File: tb/tb_fmdll_m_counter.sv
// tb_fmdll_m_counter
//   Table-driven bench for fmdll_m_counter. Each record holds the inputs for
//   one cycle and the outputs expected after that rising edge. The expected
//   outputs are queued when the inputs are driven, and then popped and
//   compared once the edge has taken effect. A hand-written sequence covers
//   an asynchronous reset while an update is pending.
module tb_fmdll_m_counter;

  typedef struct packed {
    logic       en;
    logic       ld;
    logic [1:0] req;
    logic [1:0] m;
    logic [1:0] cnt;
    logic       wrap;
    logic       sel;
    logic       busy;
    logic       err;
  } vec_t;

  logic clk_ext;
  logic rst_n;

  fmdll_m_counter_if bus ();

  fmdll_m_counter #(.M_RST(2'd2)) dut (
    .clk_ext (clk_ext),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk_ext = 1'b0;
  always #5 clk_ext = ~clk_ext;

  int         checks   = 0;
  int         failures = 0;
  vec_t       tbl [$];
  logic [7:0] sb  [$];

  function automatic vec_t mk(input logic en, input logic ld, input logic [1:0] req,
                              input logic [1:0] m, input logic [1:0] cnt, input logic wrap,
                              input logic sel, input logic busy, input logic err);
    vec_t v;
    v = {en, ld, req, m, cnt, wrap, sel, busy, err};
    return v;
  endfunction

  task automatic check_out(input string name);
    logic [7:0] act;
    logic [7:0] exp;
    act = {bus.M, bus.M_counter, bus.wrap, bus.sel_ref, bus.m_busy, bus.m_err};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, got M=%0d cnt=%0d wrap=%0b sel=%0b busy=%0b err=%0b",
               name, act[7:6], act[5:4], act[3], act[2], act[1], act[0]);
    end else begin
      exp = sb.pop_front();
      if (act !== exp) begin
        failures++;
        $display("FAIL %s: got M=%0d cnt=%0d wrap=%0b sel=%0b busy=%0b err=%0b, want M=%0d cnt=%0d wrap=%0b sel=%0b busy=%0b err=%0b",
                 name, act[7:6], act[5:4], act[3], act[2], act[1], act[0],
                 exp[7:6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk_ext);
    bus.en     = v.en;
    bus.m_load = v.ld;
    bus.m_req  = v.req;
    sb.push_back({v.m, v.cnt, v.wrap, v.sel, v.busy, v.err});
    @(posedge clk_ext);
    #1;
    check_out($sformatf("vec%0d", idx));
  endtask

  initial begin
    // en ld req | M cnt wrap sel busy err
    // Start-up with M=2 and en held high
    tbl.push_back(mk(1,0,0, 2,0,0,0,0,0)); // 0  ALIGN
    tbl.push_back(mk(1,0,0, 2,0,0,1,0,0)); // 1  RUN entry
    tbl.push_back(mk(1,0,0, 2,1,0,0,0,0));
    tbl.push_back(mk(1,0,0, 2,2,0,0,0,0));
    tbl.push_back(mk(1,0,0, 2,0,1,1,0,0)); // 4  first wrap
    tbl.push_back(mk(1,0,0, 2,1,0,0,0,0));
    tbl.push_back(mk(1,0,0, 2,2,0,0,0,0));
    tbl.push_back(mk(1,0,0, 2,0,1,1,0,0));
    // Raise M to 3, then request 1 at count 1
    tbl.push_back(mk(1,1,3, 2,1,0,0,1,0)); // 8
    tbl.push_back(mk(1,0,0, 2,2,0,0,1,0));
    tbl.push_back(mk(1,0,0, 3,0,1,1,0,0)); // 10 M=3 applied at wrap
    tbl.push_back(mk(1,0,0, 3,1,0,0,0,0));
    tbl.push_back(mk(1,1,1, 3,2,0,0,1,0)); // 12
    tbl.push_back(mk(1,0,0, 3,3,0,0,1,0));
    tbl.push_back(mk(1,0,0, 1,0,1,1,0,0)); // 14 M=1
    tbl.push_back(mk(1,0,0, 1,1,0,0,0,0));
    tbl.push_back(mk(1,0,0, 1,0,1,1,0,0));
    tbl.push_back(mk(1,0,0, 1,1,0,0,0,0));
    // Load on the wrap edge with nothing pending: it applies one wrap later
    tbl.push_back(mk(1,1,3, 1,0,1,1,1,0)); // 18
    tbl.push_back(mk(1,0,0, 1,1,0,0,1,0));
    tbl.push_back(mk(1,0,0, 3,0,1,1,0,0)); // 20
    tbl.push_back(mk(1,0,0, 3,1,0,0,0,0));
    tbl.push_back(mk(1,0,0, 3,2,0,0,0,0));
    tbl.push_back(mk(1,0,0, 3,3,0,0,0,0));
    tbl.push_back(mk(1,1,2, 3,0,1,1,1,0)); // 24 load at count==M
    tbl.push_back(mk(1,0,0, 3,1,0,0,1,0));
    tbl.push_back(mk(1,0,0, 3,2,0,0,1,0));
    tbl.push_back(mk(1,0,0, 3,3,0,0,1,0));
    tbl.push_back(mk(1,0,0, 2,0,1,1,0,0)); // 28 M=2 at following wrap
    // Illegal request handling
    tbl.push_back(mk(1,1,0, 2,1,0,0,0,1)); // 29 err set, M kept
    tbl.push_back(mk(1,0,0, 2,2,0,0,0,1));
    tbl.push_back(mk(1,0,0, 2,0,1,1,0,1)); // 31 nothing applied
    tbl.push_back(mk(1,1,1, 2,1,0,0,1,0)); // 32 legal clears err
    tbl.push_back(mk(1,1,0, 2,2,0,0,1,1)); // 33 illegal keeps pending 1
    tbl.push_back(mk(1,0,0, 1,0,1,1,0,1)); // 34 pending 1 applied
    tbl.push_back(mk(1,1,3, 1,1,0,0,1,0)); // 35
    tbl.push_back(mk(1,0,0, 3,0,1,1,0,0)); // 36
    // Drop en at count 2, apply a request while in IDLE, restart
    tbl.push_back(mk(1,0,0, 3,1,0,0,0,0));
    tbl.push_back(mk(1,0,0, 3,2,0,0,0,0));
    tbl.push_back(mk(0,0,0, 3,0,0,0,0,0)); // 39 IDLE
    tbl.push_back(mk(0,0,0, 3,0,0,0,0,0));
    tbl.push_back(mk(0,1,2, 3,0,0,0,1,0)); // 41
    tbl.push_back(mk(0,0,0, 2,0,0,0,0,0)); // 42 applied in IDLE
    tbl.push_back(mk(1,0,0, 2,0,0,0,0,0)); // 43 ALIGN
    tbl.push_back(mk(1,0,0, 2,0,0,1,0,0)); // 44 RUN entry
    tbl.push_back(mk(1,0,0, 2,1,0,0,0,0));
    tbl.push_back(mk(1,1,1, 2,2,0,0,1,0)); // 46 pending 1, reset follows
    // After the mid-operation reset: the pending ratio must not appear
    tbl.push_back(mk(0,0,0, 2,0,0,0,0,0)); // 47
    tbl.push_back(mk(0,0,0, 2,0,0,0,0,0));
    tbl.push_back(mk(1,0,0, 2,0,0,0,0,0));
    tbl.push_back(mk(1,0,0, 2,0,0,1,0,0));
    tbl.push_back(mk(1,0,0, 2,1,0,0,0,0));
    tbl.push_back(mk(1,0,0, 2,2,0,0,0,0));
    tbl.push_back(mk(1,0,0, 2,0,1,1,0,0)); // 53 still M=2

    rst_n      = 1'b0;
    bus.en     = 1'b0;
    bus.m_load = 1'b0;
    bus.m_req  = 2'd0;
    repeat (2) @(posedge clk_ext);
    #1;
    sb.push_back({2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    check_out("reset_state");
    @(negedge clk_ext);
    rst_n = 1'b1;

    for (int i = 0; i < 47; i++) apply_vec(tbl[i], i);

    // Asynchronous reset while an update is pending
    @(negedge clk_ext);
    bus.en     = 1'b0;
    bus.m_load = 1'b0;
    bus.m_req  = 2'd0;
    rst_n      = 1'b0;
    #1;
    sb.push_back({2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    check_out("async_reset");
    @(posedge clk_ext);
    #1;
    sb.push_back({2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    check_out("reset_hold");
    @(negedge clk_ext);
    rst_n = 1'b1;

    for (int i = 47; i < tbl.size(); i++) apply_vec(tbl[i], i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
